// File: rtl/bcd2421_seq_ctrl.sv
// Sequencing controller: streams the digits of a packed 8421 word, LSD first, through one
// external 8421->2421 converter and reassembles the packed 2421 result with a non-BCD mask.
module bcd2421_seq_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_code,
  output logic [DIGITS-1:0]     err_mask,
  output logic                  out_err,
  output logic                  busy,
  output logic [3:0]            conv_in,
  output logic                  conv_enb,
  input  logic [3:0]            conv_out
);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  localparam logic [2:0] LastIdx = 3'(DIGITS - 1);

  state_e                r_state;
  state_e                w_state_next;
  logic [2:0]            r_idx;
  logic [4*DIGITS-1:0]   r_hold;
  logic [4*DIGITS-1:0]   r_code;
  logic [DIGITS-1:0]     r_err;

  logic                  w_accept;
  logic                  w_last;
  logic [3:0]            w_digit;

  assign w_accept = (r_state == StIdle) && in_valid;
  assign w_last   = (r_idx == LastIdx);

  // Digit currently addressed by the index.
  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == 3'(i)) w_digit = r_hold[4*i +: 4];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (in_valid)  w_state_next = StConv;
      StConv:  if (w_last)    w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default:                w_state_next = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    conv_enb  = 1'b0;
    conv_in   = 4'd0;
    unique case (r_state)
      StIdle: in_ready = 1'b1;
      StConv: begin
        busy     = 1'b1;
        conv_enb = 1'b1;
        conv_in  = w_digit;
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath: capture on accept, fill one result digit per CONV cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx  <= 3'd0;
      r_hold <= '0;
      r_code <= '0;
      r_err  <= '0;
    end else if (w_accept) begin
      r_idx  <= 3'd0;
      r_hold <= in_bcd;
      r_code <= '0;
      r_err  <= '0;
    end else if (r_state == StConv) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (r_idx == 3'(i)) begin
          r_code[4*i +: 4] <= conv_out;
          r_err[i]         <= (w_digit > 4'd9);
        end
      end
      if (!w_last) r_idx <= r_idx + 3'd1;
    end
  end

  assign out_code = r_code;
  assign err_mask = r_err;
  assign out_err  = |r_err;

endmodule
